// File: rtl/cla16_pipe.sv
// cla16_pipe: three-stage pipelined 16-bit carry-lookahead adder.
//   S1 captures bit-level p/g and per-nibble group G/P.
//   S2 forms all group carries (and block gg/pp) with second-level lookahead.
//   S3 expands each group carry into bit carries and produces the sum.
// Each stage carries a valid bit; an elastic valid/ready chain lets a stage
// advance whenever the stage after it is empty or advancing itself.
module cla16_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        gg,
  output logic        pp
);

  // Group generate for one 4-bit nibble.
  function automatic logic grp_gen(input logic [3:0] g4, input logic [3:0] p4);
    return g4[3]
         | (p4[3] & g4[2])
         | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]);
  endfunction

  // ---------------------------------------------------------------------
  // Handshake / valid chain
  // ---------------------------------------------------------------------
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s3_v_q, s3_v_d;
  logic s1_load, s2_load, s3_load;
  logic s1_take, s2_take, s3_take;

  // Stage load enables ripple backwards from the output; in_ready never looks at in_valid.
  always_comb begin : hs_comb
    s3_load = !s3_v_q | out_ready;
    s2_load = !s2_v_q | s3_load;
    s1_load = !s1_v_q | s2_load;
    s1_take = in_valid & s1_load;
    s2_take = s1_v_q & s2_load;
    s3_take = s2_v_q & s3_load;
    s1_v_d  = s1_load ? in_valid : s1_v_q;
    s2_v_d  = s2_load ? s1_v_q   : s2_v_q;
    s3_v_d  = s3_load ? s2_v_q   : s3_v_q;
  end

  // Valid bits; async reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin : hs_ff
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s3_v_q;

  // ---------------------------------------------------------------------
  // Stage 1: bit p/g and group G/P
  // ---------------------------------------------------------------------
  logic [15:0] bit_p, bit_g;
  logic [3:0]  grp_g_w, grp_p_w;
  logic [15:0] s1_p_q, s1_p_d;
  logic [15:0] s1_g_q, s1_g_d;
  logic [3:0]  s1_gg_q, s1_gg_d;
  logic [3:0]  s1_gp_q, s1_gp_d;
  logic        s1_cin_q, s1_cin_d;

  // Bit-level and nibble-level generate/propagate from the incoming operands.
  always_comb begin : s1_comb
    bit_p = a ^ b;
    bit_g = a & b;
    grp_g_w = '0;
    grp_p_w = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      grp_g_w[k] = grp_gen(bit_g[4*k +: 4], bit_p[4*k +: 4]);
      grp_p_w[k] = &bit_p[4*k +: 4];
    end
    s1_p_d   = s1_take ? bit_p   : s1_p_q;
    s1_g_d   = s1_take ? bit_g   : s1_g_q;
    s1_gg_d  = s1_take ? grp_g_w : s1_gg_q;
    s1_gp_d  = s1_take ? grp_p_w : s1_gp_q;
    s1_cin_d = s1_take ? cin     : s1_cin_q;
  end

  // Stage 1 data registers.
  always_ff @(posedge clk or negedge rst_n) begin : s1_ff
    if (!rst_n) begin
      s1_p_q   <= '0;
      s1_g_q   <= '0;
      s1_gg_q  <= '0;
      s1_gp_q  <= '0;
      s1_cin_q <= 1'b0;
    end else begin
      s1_p_q   <= s1_p_d;
      s1_g_q   <= s1_g_d;
      s1_gg_q  <= s1_gg_d;
      s1_gp_q  <= s1_gp_d;
      s1_cin_q <= s1_cin_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: second-level lookahead over the four groups
  // ---------------------------------------------------------------------
  logic        c4_w, c8_w, c12_w, c16_w, blk_g_w, blk_p_w;
  logic [3:0]  s2_gc_q, s2_gc_d;    // carry into each group; [0] is cin
  logic        s2_c16_q, s2_c16_d;
  logic        s2_gg_q, s2_gg_d;
  logic        s2_pp_q, s2_pp_d;
  logic [15:0] s2_p_q, s2_p_d;
  logic [15:0] s2_g_q, s2_g_d;

  // Every group carry is a flat sum-of-products of G/P and cin; no inter-group ripple.
  always_comb begin : s2_comb
    c4_w  = s1_gg_q[0]
          | (s1_gp_q[0] & s1_cin_q);
    c8_w  = s1_gg_q[1]
          | (s1_gp_q[1] & s1_gg_q[0])
          | (s1_gp_q[1] & s1_gp_q[0] & s1_cin_q);
    c12_w = s1_gg_q[2]
          | (s1_gp_q[2] & s1_gg_q[1])
          | (s1_gp_q[2] & s1_gp_q[1] & s1_gg_q[0])
          | (s1_gp_q[2] & s1_gp_q[1] & s1_gp_q[0] & s1_cin_q);
    blk_g_w = s1_gg_q[3]
            | (s1_gp_q[3] & s1_gg_q[2])
            | (s1_gp_q[3] & s1_gp_q[2] & s1_gg_q[1])
            | (s1_gp_q[3] & s1_gp_q[2] & s1_gp_q[1] & s1_gg_q[0]);
    blk_p_w = &s1_gp_q;
    c16_w   = blk_g_w | (blk_p_w & s1_cin_q);

    s2_gc_d  = s2_take ? {c12_w, c8_w, c4_w, s1_cin_q} : s2_gc_q;
    s2_c16_d = s2_take ? c16_w   : s2_c16_q;
    s2_gg_d  = s2_take ? blk_g_w : s2_gg_q;
    s2_pp_d  = s2_take ? blk_p_w : s2_pp_q;
    s2_p_d   = s2_take ? s1_p_q  : s2_p_q;
    s2_g_d   = s2_take ? s1_g_q  : s2_g_q;
  end

  // Stage 2 data registers.
  always_ff @(posedge clk or negedge rst_n) begin : s2_ff
    if (!rst_n) begin
      s2_gc_q  <= '0;
      s2_c16_q <= 1'b0;
      s2_gg_q  <= 1'b0;
      s2_pp_q  <= 1'b0;
      s2_p_q   <= '0;
      s2_g_q   <= '0;
    end else begin
      s2_gc_q  <= s2_gc_d;
      s2_c16_q <= s2_c16_d;
      s2_gg_q  <= s2_gg_d;
      s2_pp_q  <= s2_pp_d;
      s2_p_q   <= s2_p_d;
      s2_g_q   <= s2_g_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: in-group carries and sum
  // ---------------------------------------------------------------------
  logic [15:0] bit_c;
  logic [15:0] s3_sum_q, s3_sum_d;
  logic        s3_cout_q, s3_cout_d;
  logic        s3_gg_q, s3_gg_d;
  logic        s3_pp_q, s3_pp_d;

  // Each group's bit carries are lookahead terms of its own carry-in and p/g.
  always_comb begin : s3_comb
    logic       ci;
    logic [3:0] gk, pk;
    bit_c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      ci = s2_gc_q[k];
      gk = s2_g_q[4*k +: 4];
      pk = s2_p_q[4*k +: 4];
      bit_c[4*k]     = ci;
      bit_c[4*k + 1] = gk[0] | (pk[0] & ci);
      bit_c[4*k + 2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & ci);
      bit_c[4*k + 3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                     | (pk[2] & pk[1] & pk[0] & ci);
    end
    s3_sum_d  = s3_take ? (s2_p_q ^ bit_c) : s3_sum_q;
    s3_cout_d = s3_take ? s2_c16_q : s3_cout_q;
    s3_gg_d   = s3_take ? s2_gg_q  : s3_gg_q;
    s3_pp_d   = s3_take ? s2_pp_q  : s3_pp_q;
  end

  // Output registers; they hold while stalled or when no new beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin : s3_ff
    if (!rst_n) begin
      s3_sum_q  <= '0;
      s3_cout_q <= 1'b0;
      s3_gg_q   <= 1'b0;
      s3_pp_q   <= 1'b0;
    end else begin
      s3_sum_q  <= s3_sum_d;
      s3_cout_q <= s3_cout_d;
      s3_gg_q   <= s3_gg_d;
      s3_pp_q   <= s3_pp_d;
    end
  end

  assign sum  = s3_sum_q;
  assign cout = s3_cout_q;
  assign gg   = s3_gg_q;
  assign pp   = s3_pp_q;

endmodule

// File: tb/tb_cla16_pipe.sv
// Self-checking bench for cla16_pipe: directed beats, backpressure, reset
// during traffic, and a randomized stream against an arithmetic reference.
module tb_cla16_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        gg;
  logic        pp;

  int checks = 0;
  int errors = 0;

  // Expected results packed as {cout, gg, pp, sum}.
  logic [18:0] exp_q[$];

  cla16_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .gg        (gg),
    .pp        (pp)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition; gg is the carry with cin forced to 0,
  // pp is "every bit position propagates".
  function automatic logic [18:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
    logic [16:0] full;
    logic [16:0] nocin;
    full  = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    nocin = {1'b0, x} + {1'b0, y};
    return {full[16], nocin[16], ((x ^ y) == 16'hFFFF), full[15:0]};
  endfunction

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || gg !== 1'b0 || pp !== 1'b0)
        begin errors++; $display("FAIL reset_outputs: got v=%b sum=%h cout=%b gg=%b pp=%b, want all 0",
                                  out_valid, sum, cout, gg, pp); end
      checks++;
      if (in_ready !== 1'b1)
        begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0)
        begin errors++; $display("FAIL post_reset_idle: out_valid=%b want 0", out_valid); end
    end
  endtask

  // One isolated beat: checks acceptance, latency and the result fields.
  task automatic test_beat(input string name, input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input logic [15:0] esum, input logic ecout,
                           input logic egg, input logic epp);
    @(negedge clk);
    a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL %s_accept: in_ready=%b want 1", name, in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    #1;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL %s_lat1: out_valid=%b want 0", name, out_valid); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL %s_lat2: out_valid=%b want 0", name, out_valid); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sum !== esum || cout !== ecout || gg !== egg || pp !== epp)
      begin errors++; $display("FAIL %s_result: got v=%b sum=%h cout=%b gg=%b pp=%b want v=1 sum=%h cout=%b gg=%b pp=%b",
                                name, out_valid, sum, cout, gg, pp, esum, ecout, egg, epp); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL %s_single_emit: out_valid=%b want 0", name, out_valid); end
  endtask

  task automatic test_backpressure;
    int k = 1;
    int acc = 0;
    int first_emit = -1;
    int last_emit = -1;
    logic [15:0] seen[$];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (k <= 5); a = 16'(k); b = 16'(k); cin = 1'b0; out_ready = 1'b0;
      #1;
      if (c >= 3) begin
        checks++;
        if (in_ready !== 1'b0)
          begin errors++; $display("FAIL bp_in_ready_full: got %b want 0 (cycle %0d)", in_ready, c); end
        checks++;
        if (out_valid !== 1'b1 || sum !== 16'h0002)
          begin errors++; $display("FAIL bp_hold: got v=%b sum=%h want v=1 sum=0002", out_valid, sum); end
      end
      if (in_valid && in_ready) begin k++; acc++; end
      @(posedge clk);
    end
    checks++;
    if (acc != 3)
      begin errors++; $display("FAIL bp_accepts: got %0d want 3", acc); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = (k <= 5); a = 16'(k); b = 16'(k); cin = 1'b0; out_ready = 1'b1;
      #1;
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1)
          begin errors++; $display("FAIL bp_pass_through: in_ready=%b want 1", in_ready); end
      end
      if (out_valid) begin
        seen.push_back(sum);
        if (first_emit < 0) first_emit = c;
        last_emit = c;
      end
      if (in_valid && in_ready) k++;
      @(posedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (seen.size() != 5)
      begin errors++; $display("FAIL bp_count: got %0d beats want 5", seen.size()); end
    for (int i = 0; i < seen.size() && i < 5; i++) begin
      checks++;
      if (seen[i] !== 16'(2 * (i + 1)))
        begin errors++; $display("FAIL bp_order: beat %0d sum=%h want %h", i, seen[i], 16'(2 * (i + 1))); end
    end
    checks++;
    if (last_emit - first_emit != 4)
      begin errors++; $display("FAIL bp_throughput: span %0d cycles want 4", last_emit - first_emit); end
  endtask

  task automatic test_reset_midstream;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); out_ready = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL mid_full: got v=%b in_ready=%b want v=1 in_ready=0", out_valid, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset: got v=%b sum=%h cout=%b in_ready=%b want 0/0000/0/1",
                                out_valid, sum, cout, in_ready); end
    @(negedge clk);
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0)
        begin errors++; $display("FAIL mid_stale: out_valid=%b want 0 (cycle %0d)", out_valid, c); end
    end
  endtask

  task automatic test_random;
    int target = 10000;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic        held_v = 1'b0;
    logic [18:0] held = '0;
    logic [18:0] obs;
    logic [18:0] exp;
    exp_q.delete();
    while (got < target && cyc < 40000) begin
      @(negedge clk);
      in_valid  = (sent < target) && ($urandom_range(3) != 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      obs = {cout, gg, pp, sum};
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held)
          begin errors++; $display("FAIL rnd_stall_hold: got v=%b %h want v=1 %h", out_valid, obs, held); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat: got %h want no beat", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp)
            begin errors++; $display("FAIL rnd_result: beat %0d got {cout,gg,pp,sum}=%h want %h", got, obs, exp); end
        end
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = obs;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, cin));
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != target || exp_q.size() != 0)
      begin errors++; $display("FAIL rnd_count: got %0d beats (%0d pending) want %0d", got, exp_q.size(), target); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_beat("single",      16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    test_beat("propagate",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    test_beat("gen_top",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    test_beat("cross_group", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
